// File: rtl/prog_delay_line.sv
// Sample-enabled delay line with run-time programmable depth and priming.
// Define PRIME_ZERO_EN to emit zero-valued valid samples while priming.
module prog_delay_line #(
    parameter  int WIDTH     = 16,
    parameter  int MAX_DEPTH = 128,
    parameter  int DEF_DLY   = 120,
    localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] Xin,
    input  logic             Vin,
    input  logic [DW-1:0]    DLY,
    output logic [WIDTH-1:0] Xout,
    output logic             Vout,
    output logic             Prim
);

    localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam int PW = DW + 1;
    localparam logic [DW-1:0] MAXD = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] DEFD = DW'(DEF_DLY);

    logic [WIDTH-1:0] mem_q [MAX_DEPTH];

    logic [AW-1:0]    wptr_q, wptr_d, raddr;
    logic [DW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    dly_q, dly_d;
    logic [DW-1:0]    eff;
    logic [WIDTH-1:0] xout_q, xout_d;
    logic             vout_q, vout_d;
    logic             prim_q, prim_d;
    logic [PW-1:0]    rsum;
    logic             upd;

    always_comb begin
        if (DLY == '0) begin
            eff = DW'(1);
        end else if (DLY > MAXD) begin
            eff = MAXD;
        end else begin
            eff = DLY;
        end
    end

    // Explicit modulo so MAX_DEPTH need not be a power of two
    always_comb begin
        rsum = PW'(wptr_q) + PW'(MAX_DEPTH) - PW'(dly_q);
        if (rsum >= PW'(MAX_DEPTH)) begin
            raddr = AW'(rsum - PW'(MAX_DEPTH));
        end else begin
            raddr = AW'(rsum);
        end
    end

    always_comb begin
        upd    = (eff != dly_q);
        wptr_d = wptr_q;
        dly_d  = dly_q;
        cnt_d  = cnt_q;
        xout_d = xout_q;
        vout_d = 1'b0;
        prim_d = (cnt_q == dly_q);
        if (Vin) begin
            if (wptr_q == AW'(MAX_DEPTH - 1)) begin
                wptr_d = '0;
            end else begin
                wptr_d = wptr_q + AW'(1);
            end
        end
        if (upd) begin
            dly_d = eff;
            cnt_d = '0;
        end else if (Vin) begin
            if (cnt_q == dly_q) begin
                xout_d = mem_q[raddr];
                vout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DW'(1);
`ifdef PRIME_ZERO_EN
                xout_d = '0;
                vout_d = 1'b1;
`else
                vout_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_q <= '0;
            cnt_q  <= '0;
            dly_q  <= DEFD;
            xout_q <= '0;
            vout_q <= 1'b0;
            prim_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            dly_q  <= dly_d;
            xout_q <= xout_d;
            vout_q <= vout_d;
            prim_q <= prim_d;
        end
    end

    // Storage is deliberately not reset; cnt gating keeps stale data hidden
    always_ff @(posedge CLK) begin
        if (Vin) begin
            mem_q[wptr_q] <= Xin;
        end
    end

    assign Xout = xout_q;
    assign Vout = vout_q;
    assign Prim = prim_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Self-checking bench for prog_delay_line: vector table, directed
// sequences and randomized traffic against a queue-based reference.
module tb_prog_delay_line;

    localparam int MAXD = 128;
    localparam int DEFD = 120;
`ifdef PRIME_ZERO_EN
    localparam logic PZ = 1'b1;
`else
    localparam logic PZ = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] Xin;
    logic        Vin;
    logic [7:0]  DLY;
    logic [15:0] Xout;
    logic        Vout;
    logic        Prim;

    always #5 CLK = ~CLK;

    prog_delay_line #(
        .WIDTH(16),
        .MAX_DEPTH(MAXD),
        .DEF_DLY(DEFD)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .Xin(Xin),
        .Vin(Vin),
        .DLY(DLY),
        .Xout(Xout),
        .Vout(Vout),
        .Prim(Prim)
    );

    int errors = 0;
    int checks = 0;

    // Reference: every accepted sample since reset, plus priming bookkeeping
    logic [15:0] hist[$];
    int          m_dly, m_cnt, m_v, m_p;
    logic [15:0] m_x;

    typedef struct {
        logic [15:0] x;
        logic        v;
        logic [7:0]  d;
        logic        ev;
        logic [15:0] ex;
        logic        ep;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int clampd(input int d);
        if (d == 0) return 1;
        if (d > MAXD) return MAXD;
        return d;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_dly = DEFD;
        m_cnt = 0;
        m_v   = 0;
        m_p   = 0;
        m_x   = '0;
    endtask

    task automatic model_step(input logic [15:0] x, input logic v,
                              input int d);
        int e;
        e   = clampd(d);
        m_p = (m_cnt == m_dly) ? 1 : 0;
        if (e != m_dly) begin
            m_dly = e;
            m_cnt = 0;
            m_v   = 0;
            if (v) hist.push_back(x);
        end else if (v) begin
            if (m_cnt == m_dly) begin
                m_x = hist[hist.size() - m_dly];
                m_v = 1;
            end else begin
                m_cnt++;
                m_v = PZ;
                if (PZ) m_x = '0;
            end
            hist.push_back(x);
        end else begin
            m_v = 0;
        end
    endtask

    task automatic cyc(input logic [15:0] x, input logic v,
                       input logic [7:0] d);
        Xin = x;
        Vin = v;
        DLY = d;
        model_step(x, v, int'(d));
        @(posedge CLK);
        #1;
        chk("model xout", Xout, m_x);
        chk("model vout", Vout, m_v);
        chk("model prim", Prim, m_p);
    endtask

    // Reset is asserted between edges and checked before the next edge
    task automatic do_reset();
        Vin = 1'b0;
        Xin = '0;
        DLY = 8'(DEFD);
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst xout", Xout, 0);
        chk("rst vout", Vout, 0);
        chk("rst prim", Prim, 0);
        model_reset();
        @(posedge CLK);
        #3;
        RST_N = 1'b1;
        cyc(16'd0, 1'b0, 8'(DEFD));
    endtask

    initial begin
        int list[8];
        int d;
        tbl[0] = '{16'd0,  1'b0, 8'd1, 1'b0, 16'd0,  1'b0};
        tbl[1] = '{16'd10, 1'b1, 8'd1, PZ,   16'd0,  1'b0};
        tbl[2] = '{16'd0,  1'b0, 8'd1, 1'b0, 16'd0,  1'b1};
        tbl[3] = '{16'd20, 1'b1, 8'd1, 1'b1, 16'd10, 1'b1};
        tbl[4] = '{16'd0,  1'b0, 8'd1, 1'b0, 16'd10, 1'b1};
        tbl[5] = '{16'd30, 1'b1, 8'd1, 1'b1, 16'd20, 1'b1};
        tbl[6] = '{16'd0,  1'b0, 8'd1, 1'b0, 16'd20, 1'b1};
        list = '{0, 1, 2, 5, 127, 128, 200, 255};

        RST_N = 1'b1;
        Vin = 1'b0;
        Xin = '0;
        DLY = 8'(DEFD);
        @(posedge CLK);
        #1;
        do_reset();

        // DLY=1 with toggling valid
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].x, tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d vout", i), Vout, tbl[i].ev);
            chk($sformatf("tbl%0d xout", i), Xout, tbl[i].ex);
            chk($sformatf("tbl%0d prim", i), Prim, tbl[i].ep);
        end

        // Default delay, continuous stream, then switch to 40 at sample 500
        do_reset();
        for (int n = 1; n <= 600; n++) begin
            cyc(16'(n), 1'b1, (n < 500) ? 8'd120 : 8'd40);
            if (n == 120) begin
                chk("d120 pre vout", Vout, PZ);
                chk("d120 pre prim", Prim, 0);
            end
            if (n == 121) begin
                chk("d120 first xout", Xout, 1);
                chk("d120 first vout", Vout, 1);
                chk("d120 first prim", Prim, 1);
            end
            if (n > 121 && n < 500) chk("d120 xout", Xout, n - 120);
            if (n == 500) chk("switch vout", Vout, 0);
            if (n == 540) chk("d40 pre vout", Vout, PZ);
            if (n == 541) begin
                chk("d40 first xout", Xout, 501);
                chk("d40 first vout", Vout, 1);
            end
        end

        // Full depth across wraps
        do_reset();
        cyc(16'd0, 1'b0, 8'd128);
        for (int n = 1; n <= 300; n++) begin
            cyc(16'(n), 1'b1, 8'd128);
            if (n == 128) chk("d128 pre vout", Vout, PZ);
            if (n >= 129) chk("d128 xout", Xout, n - 128);
        end

        // DLY=0 clamps to 1
        do_reset();
        cyc(16'd0, 1'b0, 8'd0);
        for (int n = 1; n <= 20; n++) begin
            cyc(16'(n + 1000), 1'b1, 8'd0);
            if (n >= 2) chk("d0 xout", Xout, n + 999);
        end

        // DLY=200 clamps to 128
        do_reset();
        cyc(16'd0, 1'b0, 8'd200);
        for (int n = 1; n <= 140; n++) begin
            cyc(16'(n), 1'b1, 8'd200);
            if (n >= 129) chk("d200 xout", Xout, n - 128);
        end

        // Asynchronous reset mid-stream, then re-prime from scratch
        do_reset();
        for (int n = 1; n <= 130; n++) cyc(16'(n + 7), 1'b1, 8'd120);
        chk("mid vout before rst", Vout, 1);
        do_reset();
        for (int n = 1; n <= 125; n++) begin
            cyc(16'(n), 1'b1, 8'd120);
            if (n == 1) chk("re xout", Xout, 0);
            if (n == 120) chk("re pre vout", Vout, PZ);
            if (n == 121) begin
                chk("re first xout", Xout, 1);
                chk("re first vout", Vout, 1);
            end
        end

        // Randomized traffic with occasional delay changes
        do_reset();
        d = DEFD;
        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 0) d = list[$urandom_range(0, 7)];
            cyc(16'($urandom), ($urandom_range(0, 9) < 7), 8'(d));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
